// File: rtl/digit_serial_addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor: FSM states, op codes, result flags.
package digit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic c_out;
        logic overflow;
        logic zero;
    } flags_t;

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Request/result bundle between the command parser, the adder and the result formatter.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, op, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, zero, busy
    );

    modport slave (
        input  in_valid, a, b, op, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, zero, busy
    );
endinterface

// File: rtl/digit_serial_addsub_digit_adder.sv
// DIGIT-bit ripple adder slice, shared across all digit positions.
// Latency: combinational.
// Backpressure: none (pure logic).
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c_in,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_c_out,
    output logic             o_c_msb_in
);
    logic [DIGIT:0] w_full;

    assign w_full     = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_c_in};
    assign o_sum      = w_full[DIGIT-1:0];
    assign o_c_out    = w_full[DIGIT];
    // Carry into the top bit falls out of the top sum bit and its two operand bits.
    assign o_c_msb_in = w_full[DIGIT-1] ^ i_a[DIGIT-1] ^ i_b[DIGIT-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract, one DIGIT-bit slice per clock, LS slice first.
// Latency: out_valid rises NUM_DIGITS edges after the accepting edge.
// Backpressure: holds result and flags in DONE until out_ready; in_ready low while busy.
module digit_serial_addsub
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    digit_serial_addsub_if.slave  bus
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_op;
    flags_t           r_flags;

    logic [31:0]      w_shamt;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_dig_sum;
    logic             w_dig_c;
    logic             w_dig_msb_c;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_last;

    assign w_shamt   = 32'(r_cnt) * 32'(DIGIT);
    assign w_a_dig   = DIGIT'(r_a >> w_shamt);
    assign w_b_dig   = DIGIT'(r_b >> w_shamt);
    // Sum is cleared on accept, so OR-ing each new slice into place assembles it.
    assign w_sum_nxt = r_sum | (WIDTH'(w_dig_sum) << w_shamt);
    assign w_last    = (r_cnt == LAST_CNT);

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .i_a        (w_a_dig),
        .i_b        (w_b_dig),
        .i_c_in     (r_carry),
        .o_sum      (w_dig_sum),
        .o_c_out    (w_dig_c),
        .o_c_msb_in (w_dig_msb_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_op    <= OP_ADD;
            r_flags <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract as a + ~b + 1; borrow-in folds into that +1.
                        r_a     <= bus.a;
                        r_b     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        r_carry <= bus.c_in ^ bus.op;
                        r_op    <= bus.op;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_dig_c;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_flags.c_out    <= w_dig_c ^ r_op;
                        r_flags.overflow <= w_dig_msb_c ^ w_dig_c;
                        r_flags.zero     <= (w_sum_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum      = r_sum;
    assign bus.c_out    = r_flags.c_out;
    assign bus.overflow = r_flags.overflow;
    assign bus.zero     = r_flags.zero;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed checks of the digit-serial adder at 32/4 and 8/4 geometries.
module tb_digit_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    digit_serial_addsub_if #(.WIDTH(32)) bus ();
    digit_serial_addsub_if #(.WIDTH(8))  bus8 ();

    digit_serial_addsub #(.WIDTH(32), .DIGIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    digit_serial_addsub #(.WIDTH(8), .DIGIT(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input string tag, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
        check({tag, "_rdy"}, bus.in_ready, 1);
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        bus.c_in     = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.op       = ~op;
        bus.c_in     = ~cin;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 8);
    endtask

    task automatic expect_res(input string tag, input logic [31:0] s, input logic c,
                              input logic ov, input logic z);
        check({tag, "_sum"}, bus.sum, s);
        check({tag, "_cout"}, bus.c_out, c);
        check({tag, "_ovf"}, bus.overflow, ov);
        check({tag, "_zero"}, bus.zero, z);
        check({tag, "_busy"}, bus.busy, 1);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_vld_low"}, bus.out_valid, 0);
        check({tag, "_rdy_back"}, bus.in_ready, 1);
    endtask

    task automatic run(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, input logic [31:0] s,
                       input logic c, input logic ov, input logic z);
        start(tag, op, a, b, cin);
        wait_done(tag);
        expect_res(tag, s, c, ov, z);
        drain(tag);
    endtask

    task automatic run8(input string tag, input logic op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input logic [7:0] s,
                        input logic c, input logic ov);
        int lat;
        check({tag, "_rdy"}, bus8.in_ready, 1);
        bus8.a        = a;
        bus8.b        = b;
        bus8.op       = op;
        bus8.c_in     = cin;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_sum"}, bus8.sum, s);
        check({tag, "_cout"}, bus8.c_out, c);
        check({tag, "_ovf"}, bus8.overflow, ov);
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
        check({tag, "_vld_low"}, bus8.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 1'b0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.op        = 1'b0;
        bus8.c_in      = 1'b0;
        bus8.out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.c_out, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_zero", bus.zero, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run("sub_neg",  1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        run("add_ovf",  1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run("sub_ovf",  1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run("add_cin",  1'b0, 32'h0000_000F, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        run("sub_bin",  1'b1, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'h0000_000F, 1'b0, 1'b0, 1'b0);

        // Consumer already ready: result leaves on the first out_valid cycle.
        bus.out_ready = 1'b1;
        start("pre_rdy", 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        wait_done("pre_rdy");
        check("pre_rdy_sum", bus.sum, 32'h0001_0000);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("pre_rdy_vld_low", bus.out_valid, 0);
        check("pre_rdy_in_rdy", bus.in_ready, 1);

        // Backpressure in DONE while inputs churn.
        start("bp", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0);
        wait_done("bp");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.a        = $urandom;
            bus.b        = $urandom;
            bus.op       = i[1];
            @(posedge clk);
            #1;
            check("bp_sum", bus.sum, 32'hFFFF_FFFE);
            check("bp_cout", bus.c_out, 1);
            check("bp_vld", bus.out_valid, 1);
            check("bp_in_rdy", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        drain("bp");
        check("bp_sum_held", bus.sum, 32'hFFFF_FFFE);

        // Reset at digit 3 of a RUN discards the partial result.
        start("abort", 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_mid", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_rdy", bus.in_ready, 1);
        check("abort_vld", bus.out_valid, 0);
        check("abort_sum", bus.sum, 0);
        check("abort_busy", bus.busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_vld", bus.out_valid, 0);
        run("post_rst", 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        run8("w8_add", 1'b0, 8'hF0, 8'h10, 1'b1, 8'h01, 1'b1, 1'b0);
        run8("w8_sub", 1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
